mem_wb_elastic_reg: RTL and testbench
=====================================

Name: mem_wb_elastic_reg

Overview:
- Parametrised successor to the MEM→WB pipeline register: a 2-entry elastic (skid) buffer carrying write-back control, destination register, ALU result and memory data.
- Adds a valid/ready handshake on both sides, a synchronous flush and occupancy reporting.
- Adds a registered-source forwarding port (dest plus selected write-back value) for the hazard/forwarding unit.
- Sits between the MEM stage and the WB stage, so that memory-side stalls no longer freeze the whole pipeline.

Parameters:
WORD_WIDTH, 32, width of ALU result, memory data and forwarded value
REG_FILE_DEPTH, 4, width of destination register index

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0), clears all state
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  buffer can accept an entry this cycle
MEM_R_EN_in  in  1  entry is a load
WB_EN_in  in  1  entry writes the register file
Dest_in  in  REG_FILE_DEPTH  destination register
ALU_Res_in  in  WORD_WIDTH  ALU result / address
MEM_in  in  WORD_WIDTH  load data
out_valid  out  1  head entry presented to WB
out_ready  in  1  WB consumes head entry
MEM_R_EN_out  out  1  head field
WB_EN_out  out  1  head field
Dest_out  out  REG_FILE_DEPTH  head field
ALU_Res_out  out  WORD_WIDTH  head field
MEM_out  out  WORD_WIDTH  head field
fwd_valid  out  1  out_valid & WB_EN_out
fwd_dest  out  REG_FILE_DEPTH  equals Dest_out
fwd_value  out  WORD_WIDTH  MEM_R_EN_out ? MEM_out : ALU_Res_out
count  out  2  occupancy, 0..2

Behaviour:
- Storage: two entry registers (head, tail) plus a 2-bit count; each entry holds {MEM_R_EN, WB_EN, Dest, ALU_Res, MEM}.
- Reset (rst=0, async): count=0, both entries all-zero. Hence out_valid=0, in_ready=1, and every data/forward output is 0.
- in_ready = (count != 2). It depends only on state, with no combinational path from out_ready.
- push = in_valid & in_ready; pop = out_valid & out_ready; out_valid = (count != 0).
- Latency: an entry pushed in cycle N appears on the outputs in cycle N+1 when the buffer was empty. Throughput is 1 entry/cycle while out_ready=1.
- count transitions:
  - 0: push→1.
  - 1: push&pop→1 (head←new entry); push only→2 (tail←new entry); pop only→0.
  - 2: pop→1 (head←tail). push is impossible because in_ready=0.
- Ordering: strictly FIFO; entries are never reordered or duplicated.
- Outputs when count=0: every head field and forward output reads 0, not stale data. Verification checks this.
- flush=1 at a clock edge: count←0 and entries zeroed. This overrides any push/pop in the same cycle, and the incoming entry is discarded. in_valid is ignored during flush.
- Reset asserted mid-transfer: the entry is lost; outputs go to 0 immediately (asynchronously), not at the next edge.
- fwd_value selection is combinational from head registers only; no input-to-output combinational path exists in the block.
- Input fields are ignored when in_valid=0; the held state is unchanged.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles with random inputs -> out_valid=0, in_ready=1, count=0, all outputs 0; release rst -> unchanged until in_valid.
2. Streaming: out_ready=1, push Dest=3/ALU=0x10, Dest=5/ALU=0x20, Dest=7/ALU=0x30 on consecutive cycles -> same sequence on outputs one cycle later, count stays 1, in_ready stays 1.
3. Backpressure: out_ready=0, push A(Dest=1), B(Dest=2), offer C -> count=2, in_ready=0, C not accepted. Raise out_ready -> A, then B, then C (re-offered) delivered in order.
4. Forwarding: push MEM_R_EN=1, WB_EN=1, ALU=0x100, MEM=0xDEAD, Dest=9 -> fwd_valid=1, fwd_dest=9, fwd_value=0xDEAD. Push WB_EN=0 -> fwd_valid=0.
5. Flush with simultaneous push: count=2 and in_valid=1 at the flush edge -> next cycle count=0, out_valid=0, outputs 0, pushed entry absent.
6. Async reset mid-operation: count=2, drop rst between clock edges -> outputs 0 and count=0 before the next rising edge.

Source files
------------

// File: rtl/mem_wb_elastic_reg.sv
// mem_wb_elastic_reg: 2-entry elastic (skid) register between the MEM and WB stages.
//
// Ports:
//   clk, rst (async, active-low), flush (sync, discards all held entries)
//   in_valid / in_ready                              MEM-side handshake
//   MEM_R_EN_in, WB_EN_in, Dest_in, ALU_Res_in, MEM_in   incoming entry fields
//   out_valid / out_ready                            WB-side handshake
//   MEM_R_EN_out, WB_EN_out, Dest_out, ALU_Res_out, MEM_out   head entry fields
//   fwd_valid, fwd_dest, fwd_value                   registered-source forwarding port
//   count                                            occupancy (0..2)
//
// in_ready depends only on the occupancy, so there is no path from out_ready to in_ready.
// All outputs come from registers, so nothing passes combinationally from the inputs.
module mem_wb_elastic_reg #(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned REG_FILE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      MEM_R_EN_in,
    input  logic                      WB_EN_in,
    input  logic [REG_FILE_DEPTH-1:0] Dest_in,
    input  logic [WORD_WIDTH-1:0]     ALU_Res_in,
    input  logic [WORD_WIDTH-1:0]     MEM_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      MEM_R_EN_out,
    output logic                      WB_EN_out,
    output logic [REG_FILE_DEPTH-1:0] Dest_out,
    output logic [WORD_WIDTH-1:0]     ALU_Res_out,
    output logic [WORD_WIDTH-1:0]     MEM_out,
    output logic                      fwd_valid,
    output logic [REG_FILE_DEPTH-1:0] fwd_dest,
    output logic [WORD_WIDTH-1:0]     fwd_value,
    output logic [1:0]                count
);

    // Entry layout: {MEM_R_EN, WB_EN, Dest, ALU_Res, MEM}
    localparam int unsigned EntryW = 2 + REG_FILE_DEPTH + 2 * WORD_WIDTH;

    logic [EntryW-1:0] head_q, head_d;
    logic [EntryW-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic [EntryW-1:0] in_entry;
    logic [EntryW-1:0] head_vis;
    logic              push;
    logic              pop;

    assign in_entry  = {MEM_R_EN_in, WB_EN_in, Dest_in, ALU_Res_in, MEM_in};

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = in_entry;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        tail_d  = in_entry;
                        count_d = 2'd2;
                    end else if (pop) begin
                        head_d  = '0;
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_d  = tail_q;
                        tail_d  = '0;
                        count_d = 2'd1;
                    end
                end
                default: begin
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Gate with out_valid so an empty buffer never shows stale head contents.
    assign head_vis = out_valid ? head_q : '0;

    assign {MEM_R_EN_out, WB_EN_out, Dest_out, ALU_Res_out, MEM_out} = head_vis;

    assign fwd_valid = out_valid & WB_EN_out;
    assign fwd_dest  = Dest_out;
    assign fwd_value = MEM_R_EN_out ? MEM_out : ALU_Res_out;
    assign count     = count_q;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Bench for mem_wb_elastic_reg: directed steps followed by a randomized phase, all checked
// against a queue-based reference model of a 2-deep FIFO.
module tb_mem_wb_elastic_reg;

    typedef struct packed {
        logic        mr;
        logic        wb;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] mem;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    entry_t      din = '0;

    logic        in_ready, out_valid;
    logic        MEM_R_EN_out, WB_EN_out;
    logic [3:0]  Dest_out;
    logic [31:0] ALU_Res_out, MEM_out;
    logic        fwd_valid;
    logic [3:0]  fwd_dest;
    logic [31:0] fwd_value;
    logic [1:0]  count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    entry_t      q[$];

    always #5 clk = ~clk;

    mem_wb_elastic_reg #(
        .WORD_WIDTH    (32),
        .REG_FILE_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .MEM_R_EN_in (din.mr),
        .WB_EN_in    (din.wb),
        .Dest_in     (din.dest),
        .ALU_Res_in  (din.alu),
        .MEM_in      (din.mem),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .MEM_R_EN_out(MEM_R_EN_out),
        .WB_EN_out   (WB_EN_out),
        .Dest_out    (Dest_out),
        .ALU_Res_out (ALU_Res_out),
        .MEM_out     (MEM_out),
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_value   (fwd_value),
        .count       (count)
    );

    function automatic entry_t rand_entry();
        entry_t e;
        e.mr   = 1'($urandom);
        e.wb   = 1'($urandom);
        e.dest = 4'($urandom);
        e.alu  = $urandom;
        e.mem  = $urandom;
        return e;
    endfunction

    function automatic entry_t mk(logic mr, logic wb, logic [3:0] dest, logic [31:0] alu,
                                  logic [31:0] mem);
        entry_t e;
        e.mr = mr; e.wb = wb; e.dest = dest; e.alu = alu; e.mem = mem;
        return e;
    endfunction

    // One rising edge; the model applies the FIFO rules using the pre-edge occupancy.
    task automatic tick();
        bit     do_push, do_pop;
        entry_t e;
        do_push = in_valid && (q.size() < 2);
        do_pop  = (q.size() > 0) && out_ready;
        e       = din;
        @(posedge clk);
        #1;
        if (!rst || flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    endtask

    task automatic check(string tag);
        entry_t      h;
        logic [3:0]  exp_ctrl;
        logic [41:0] exp_fwd;
        h        = (q.size() > 0) ? q[0] : '0;
        exp_ctrl = {q.size() > 0, q.size() < 2, 2'(q.size())};
        exp_fwd  = {h.wb && (q.size() > 0), h.dest, h.mr ? h.mem : h.alu};
        n_cmp++;
        assert ({out_valid, in_ready, count} === exp_ctrl) else begin
            n_bad++;
            $error("FAIL %s ctrl got=%h want=%h", tag, {out_valid, in_ready, count}, exp_ctrl);
        end
        n_cmp++;
        assert ({MEM_R_EN_out, WB_EN_out, Dest_out, ALU_Res_out, MEM_out} === h) else begin
            n_bad++;
            $error("FAIL %s head got=%h want=%h", tag,
                   {MEM_R_EN_out, WB_EN_out, Dest_out, ALU_Res_out, MEM_out}, h);
        end
        n_cmp++;
        assert ({fwd_valid, fwd_dest, fwd_value} === exp_fwd) else begin
            n_bad++;
            $error("FAIL %s fwd got=%h want=%h", tag, {fwd_valid, fwd_dest, fwd_value}, exp_fwd);
        end
    endtask

    initial begin
        // 1. Reset held with random inputs, then idle.
        #1;
        check("reset_t0");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom); din = rand_entry();
            tick();
            check("reset_hold");
        end
        rst = 1'b1; in_valid = 1'b0; din = rand_entry();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle");
        end

        // 2. Streaming with out_ready high.
        out_ready = 1'b1;
        in_valid = 1'b1; din = mk(1'b0, 1'b1, 4'd3, 32'h10, 32'h0); tick(); check("stream_a");
        in_valid = 1'b1; din = mk(1'b0, 1'b1, 4'd5, 32'h20, 32'h0); tick(); check("stream_b");
        in_valid = 1'b1; din = mk(1'b0, 1'b1, 4'd7, 32'h30, 32'h0); tick(); check("stream_c");
        in_valid = 1'b0; tick(); check("stream_drain");

        // 3. Backpressure: A and B fill the buffer, C is refused until space opens.
        out_ready = 1'b0;
        in_valid = 1'b1; din = mk(1'b0, 1'b1, 4'd1, 32'hA, 32'h0); tick(); check("bp_a");
        din = mk(1'b0, 1'b1, 4'd2, 32'hB, 32'h0); tick(); check("bp_b");
        din = mk(1'b0, 1'b1, 4'd4, 32'hC, 32'h0); tick(); check("bp_c_refused");
        tick(); check("bp_c_still_refused");
        out_ready = 1'b1;
        tick(); check("bp_deliver_b");
        tick(); check("bp_deliver_c");
        in_valid = 1'b0; tick(); check("bp_empty");

        // 4. Forwarding selects load data for loads, ALU result otherwise.
        in_valid = 1'b1; din = mk(1'b1, 1'b1, 4'd9, 32'h100, 32'hDEAD); tick(); check("fwd_load");
        din = mk(1'b0, 1'b0, 4'd6, 32'h200, 32'hBEEF); tick(); check("fwd_nowb");
        in_valid = 1'b0; tick(); check("fwd_empty");

        // 5. Flush with a simultaneous push while full.
        out_ready = 1'b0; in_valid = 1'b1;
        din = rand_entry(); tick();
        din = rand_entry(); tick(); check("flush_full");
        din = rand_entry(); flush = 1'b1; tick(); check("flush_done");
        flush = 1'b0; in_valid = 1'b0; tick(); check("flush_after");

        // 6. Async reset between edges while full.
        in_valid = 1'b1;
        din = rand_entry(); tick();
        din = rand_entry(); tick(); check("areset_full");
        #2 rst = 1'b0;
        #1 q.delete();
        check("areset_immediate");
        tick(); check("areset_held");
        rst = 1'b1; in_valid = 1'b0; tick(); check("areset_release");

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            din       = rand_entry();
            tick();
            check("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
